// File: rtl/add_sub_pkg.sv
// Shared types for the adder/subtractor checker and its reference model.
package add_sub_pkg;

   typedef logic signed [15:0] word_t;

   // One adder/subtractor outcome: result word, signed overflow and raw carry-out.
   typedef struct packed {
      word_t Out;
      logic  over;
      logic  carry;
   } add_sub_res_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   // True when an observed outcome differs from the expected one in any field.
   function automatic logic res_mismatch(input add_sub_res_t obs, input add_sub_res_t exp);
      return (obs != exp);
   endfunction

endpackage

// File: rtl/add_sub_ref.sv
// Combinational golden model of the 16-bit adder/subtractor.
// Subtract is done as op1 + ~op2 + 1, so carry is the raw carry-out (1 = no borrow).
module add_sub_ref
   import add_sub_pkg::*;
(
   input  word_t        op1,
   input  word_t        op2,
   input  logic         Op,
   output add_sub_res_t res
);

   logic [15:0] w_b;
   logic [16:0] w_sum;

   // Form the second adder operand and the 17-bit sum, then derive the flags.
   always_comb begin
      w_b       = Op ? ~op2 : op2;
      w_sum     = {1'b0, op1} + {1'b0, w_b} + {16'd0, Op};
      res.Out   = w_sum[15:0];
      res.carry = w_sum[16];
      // Overflow: adder operand signs agree but the result sign does not.
      res.over  = (op1[15] == w_b[15]) && (w_sum[15] != op1[15]);
   end

endmodule

// File: rtl/add_sub_checker.sv
// Two-stage checker that compares an observed adder/subtractor against add_sub_ref,
// counts checked/mismatched transactions and captures the first mismatch.
module add_sub_checker
   import add_sub_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int DW    = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] op1,
   input  logic signed [DW-1:0] op2,
   input  logic                 Op,
   input  logic signed [DW-1:0] Out,
   input  logic                 over,
   input  logic                 carry,
   input  logic                 clr,
   input  logic                 halt_on_err,
   output logic [CNT_W-1:0]     chk_count,
   output logic [CNT_W-1:0]     err_count,
   output logic                 err_flag,
   output logic signed [DW-1:0] first_op1,
   output logic signed [DW-1:0] first_op2,
   output logic signed [DW-1:0] first_out,
   output logic                 first_op
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t       r_state;
   state_t       w_state_nxt;
   logic         w_accept;
   add_sub_res_t w_exp;
   add_sub_res_t w_obs;

   // Stage 1: accepted transaction and its expected result.
   logic         r_s1_valid;
   word_t        r_s1_op1;
   word_t        r_s1_op2;
   logic         r_s1_op;
   add_sub_res_t r_s1_obs;
   add_sub_res_t r_s1_exp;
   logic         w_s1_mis;

   // Stage 2: comparison outcome plus the data needed for first-error capture.
   logic         r_s2_valid;
   logic         r_s2_mis;
   word_t        r_s2_op1;
   word_t        r_s2_op2;
   word_t        r_s2_out;
   logic         r_s2_op;
   logic         w_cmp_mis;

   logic [CNT_W-1:0] r_chk;
   logic [CNT_W-1:0] r_err;
   logic             r_flag;
   word_t            r_f_op1;
   word_t            r_f_op2;
   word_t            r_f_out;
   logic             r_f_op;

   add_sub_ref u_ref (
      .op1 (op1),
      .op2 (op2),
      .Op  (Op),
      .res (w_exp)
   );

   assign in_ready  = (r_state == RUN);
   assign w_accept  = in_valid && in_ready;
   assign w_s1_mis  = r_s1_valid && res_mismatch(r_s1_obs, r_s1_exp);
   assign w_cmp_mis = r_s2_valid && r_s2_mis;

   // Pack the observed adder outputs into the shared result struct.
   always_comb begin
      w_obs.Out   = Out;
      w_obs.over  = over;
      w_obs.carry = carry;
   end

   // Stage 1 capture of the accepted transaction and its expected result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op1   <= 16'sd0;
         r_s1_op2   <= 16'sd0;
         r_s1_op    <= 1'b0;
         r_s1_obs   <= '0;
         r_s1_exp   <= '0;
      end else if (clr) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_op1 <= op1;
            r_s1_op2 <= op2;
            r_s1_op  <= Op;
            r_s1_obs <= w_obs;
            r_s1_exp <= w_exp;
         end
      end
   end

   // Stage 2 registers the comparison so counters update two edges after acceptance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_mis   <= 1'b0;
         r_s2_op1   <= 16'sd0;
         r_s2_op2   <= 16'sd0;
         r_s2_out   <= 16'sd0;
         r_s2_op    <= 1'b0;
      end else if (clr) begin
         r_s2_valid <= 1'b0;
         r_s2_mis   <= 1'b0;
      end else begin
         r_s2_valid <= r_s1_valid;
         r_s2_mis   <= w_s1_mis;
         r_s2_op1   <= r_s1_op1;
         r_s2_op2   <= r_s1_op2;
         r_s2_out   <= r_s1_obs.Out;
         r_s2_op    <= r_s1_op;
      end
   end

   // Next-state logic: a counted mismatch with halt_on_err stops acceptance; HALT holds.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN: begin
            if (w_cmp_mis && halt_on_err) begin
               w_state_nxt = HALT;
            end else begin
               w_state_nxt = RUN;
            end
         end
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = RUN;
      endcase
   end

   // State register; only reset or clr returns the checker to RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else if (clr) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Saturating counters, sticky error flag and first-mismatch capture.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         r_chk   <= '0;
         r_err   <= '0;
         r_flag  <= 1'b0;
         r_f_op1 <= 16'sd0;
         r_f_op2 <= 16'sd0;
         r_f_out <= 16'sd0;
         r_f_op  <= 1'b0;
      end else begin
         if (r_s2_valid && (r_chk != CNT_MAX)) begin
            r_chk <= r_chk + CNT_ONE;
         end
         if (w_cmp_mis && (r_err != CNT_MAX)) begin
            r_err <= r_err + CNT_ONE;
         end
         if (w_cmp_mis) begin
            r_flag <= 1'b1;
         end
         if (w_cmp_mis && !r_flag) begin
            r_f_op1 <= r_s2_op1;
            r_f_op2 <= r_s2_op2;
            r_f_out <= r_s2_out;
            r_f_op  <= r_s2_op;
         end
      end
   end

   assign chk_count = r_chk;
   assign err_count = r_err;
   assign err_flag  = r_flag;
   assign first_op1 = r_f_op1;
   assign first_op2 = r_f_op2;
   assign first_out = r_f_out;
   assign first_op  = r_f_op;

endmodule

// File: tb/tb_add_sub_checker.sv
// Randomized self-checking bench for add_sub_checker against an arithmetic reference.
module tb_add_sub_checker;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] op1;
   logic [15:0] op2;
   logic        Op;
   logic [15:0] Out;
   logic        over;
   logic        carry;
   logic        clr;
   logic        halt_on_err;

   logic        in_ready;
   logic [15:0] chk_count;
   logic [15:0] err_count;
   logic        err_flag;
   logic [15:0] first_op1;
   logic [15:0] first_op2;
   logic [15:0] first_out;
   logic        first_op;

   logic        d4_in_ready;
   logic [3:0]  d4_chk_count;
   logic [3:0]  d4_err_count;
   logic        d4_err_flag;
   logic [15:0] d4_first_op1;
   logic [15:0] d4_first_op2;
   logic [15:0] d4_first_out;
   logic        d4_first_op;

   int n_checks;
   int n_errors;

   // Reference state: unsaturated counts, halt flag, first-error capture, latency line.
   typedef struct {
      bit          v;
      bit          mis;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] o;
      bit          op;
   } ent_t;

   ent_t        dq[$];
   int          m_chk;
   int          m_err;
   bit          m_halt;
   bit          m_flag;
   logic [15:0] m_f1;
   logic [15:0] m_f2;
   logic [15:0] m_fo;
   bit          m_fop;

   add_sub_checker u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .Op(Op), .Out(Out), .over(over), .carry(carry),
      .clr(clr), .halt_on_err(halt_on_err),
      .chk_count(chk_count), .err_count(err_count), .err_flag(err_flag),
      .first_op1(first_op1), .first_op2(first_op2), .first_out(first_out),
      .first_op(first_op)
   );

   add_sub_checker #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_in_ready),
      .op1(op1), .op2(op2), .Op(Op), .Out(Out), .over(over), .carry(carry),
      .clr(clr), .halt_on_err(halt_on_err),
      .chk_count(d4_chk_count), .err_count(d4_err_count), .err_flag(d4_err_flag),
      .first_op1(d4_first_op1), .first_op2(d4_first_op2), .first_out(d4_first_out),
      .first_op(d4_first_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   // Plain integer arithmetic: unsigned sum for carry/result, signed sum for overflow.
   function automatic void ref_calc(input logic [15:0] a, input logic [15:0] b, input bit op,
                                    output logic [15:0] o, output bit ov, output bit cy);
      int ua, ub, s, sa, sb, sr;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (!op) begin
         s  = ua + ub;
         sr = sa + sb;
      end else begin
         s  = ua + (65535 - ub) + 1;
         sr = sa - sb;
      end
      cy = (s >= 65536);
      o  = s[15:0];
      ov = (sr > 32767) || (sr < -32768);
   endfunction

   // One clock cycle: drive at negedge, advance the reference at posedge, compare after.
   task automatic cyc(input bit v, input logic [15:0] a, input logic [15:0] b, input bit op,
                      input logic [15:0] o, input bit ov, input bit cy,
                      input bit c, input bit h, input bit r);
      logic [15:0] eo;
      bit          eov, ecy, acc;
      ent_t        e;
      ent_t        p;
      @(negedge clk);
      in_valid = v; op1 = a; op2 = b; Op = op; Out = o; over = ov; carry = cy;
      clr = c; halt_on_err = h; rst_n = r;
      ref_calc(a, b, op, eo, eov, ecy);
      acc   = v && !m_halt;
      e.v   = acc;
      e.mis = (o != eo) || (ov != eov) || (cy != ecy);
      e.a = a; e.b = b; e.o = o; e.op = op;
      @(posedge clk);
      if (!r || c) begin
         dq.delete();
         m_chk = 0; m_err = 0; m_halt = 1'b0; m_flag = 1'b0;
         m_f1 = 16'd0; m_f2 = 16'd0; m_fo = 16'd0; m_fop = 1'b0;
      end else begin
         if (dq.size() == 2) begin
            p = dq.pop_front();
            if (p.v) begin
               m_chk++;
               if (p.mis) begin
                  m_err++;
                  if (!m_flag) begin
                     m_f1 = p.a; m_f2 = p.b; m_fo = p.o; m_fop = p.op;
                  end
                  m_flag = 1'b1;
                  if (h) m_halt = 1'b1;
               end
            end
         end
         dq.push_back(e);
      end
      #1;
      check_val("in_ready",   {31'd0, in_ready},  {31'd0, !m_halt});
      check_val("chk_count",  {16'd0, chk_count}, sat(m_chk, 16));
      check_val("err_count",  {16'd0, err_count}, sat(m_err, 16));
      check_val("err_flag",   {31'd0, err_flag},  {31'd0, m_flag});
      check_val("first_op1",  {16'd0, first_op1}, {16'd0, m_f1});
      check_val("first_op2",  {16'd0, first_op2}, {16'd0, m_f2});
      check_val("first_out",  {16'd0, first_out}, {16'd0, m_fo});
      check_val("first_op",   {31'd0, first_op},  {31'd0, m_fop});
      check_val("chk_count4", {28'd0, d4_chk_count}, sat(m_chk, 4));
      check_val("err_count4", {28'd0, d4_err_count}, sat(m_err, 4));
      check_val("in_ready4",  {31'd0, d4_in_ready}, {31'd0, !m_halt});
   endtask

   task automatic good(input logic [15:0] a, input logic [15:0] b, input bit op, input bit h);
      logic [15:0] o;
      bit ov, cy;
      ref_calc(a, b, op, o, ov, cy);
      cyc(1'b1, a, b, op, o, ov, cy, 1'b0, h, 1'b1);
   endtask

   task automatic idle(input int n, input bit h);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, h, 1'b1);
   endtask

   task automatic do_clr(input bit h);
      cyc(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, h, 1'b1);
   endtask

   function automatic logic [15:0] pick_word();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h7FFF;
         2:       return 16'h8000;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      logic [15:0] ra, rb, ro;
      bit rop, rov, rcy, rv, rc, rh, rr;
      int k;
      n_checks = 0; n_errors = 0;
      m_chk = 0; m_err = 0; m_halt = 1'b0; m_flag = 1'b0;
      m_f1 = 16'd0; m_f2 = 16'd0; m_fo = 16'd0; m_fop = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; op1 = 16'd0; op2 = 16'd0; Op = 1'b0;
      Out = 16'd0; over = 1'b0; carry = 1'b0; clr = 1'b0; halt_on_err = 1'b0;

      // Reset, then reset state.
      cyc(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("rst_ready", {31'd0, in_ready}, 32'd1);
      check_val("rst_chk", {16'd0, chk_count}, 32'd0);
      idle(1, 1'b0);

      // Add 2000 + 1000.
      cyc(1'b1, 16'd2000, 16'd1000, 1'b0, 16'd3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      check_val("add_chk", {16'd0, chk_count}, 32'd1);
      check_val("add_err", {16'd0, err_count}, 32'd0);

      // Subtract with raw carry, and negative add with carry.
      cyc(1'b1, 16'd2000, 16'd1000, 1'b1, 16'd1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, -16'sd2000, -16'sd1000, 1'b0, -16'sd3000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      check_val("sub_chk", {16'd0, chk_count}, 32'd3);
      check_val("sub_err", {16'd0, err_count}, 32'd0);

      // Overflow reported correctly, then the same with over missing.
      cyc(1'b1, 16'd32767, 16'd1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      check_val("ovf_ok", {16'd0, err_count}, 32'd0);
      cyc(1'b1, 16'd32767, 16'd1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      check_val("ovf_bad", {16'd0, err_count}, 32'd1);

      // First mismatch capture and its latency.
      do_clr(1'b0);
      cyc(1'b1, 16'd2000, 16'd1000, 1'b0, 16'd2999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0);
      check_val("flag_early", {31'd0, err_flag}, 32'd0);
      idle(1, 1'b0);
      check_val("flag_set", {31'd0, err_flag}, 32'd1);
      check_val("first_out_v", {16'd0, first_out}, 32'd2999);
      check_val("first_op_v", {31'd0, first_op}, 32'd0);
      cyc(1'b1, 16'd5, 16'd3, 1'b1, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      check_val("first_hold", {16'd0, first_out}, 32'd2999);
      check_val("err_two", {16'd0, err_count}, 32'd2);

      // Halt on error, halt_on_err change ignored, clr resumes.
      do_clr(1'b1);
      cyc(1'b1, 16'd2000, 16'd1000, 1'b0, 16'd2999, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1, 1'b1);
      check_val("halt_pre", {31'd0, in_ready}, 32'd1);
      idle(1, 1'b1);
      check_val("halt_now", {31'd0, in_ready}, 32'd0);
      good(16'd1, 16'd2, 1'b0, 1'b0);
      idle(3, 1'b0);
      check_val("halt_hold", {31'd0, in_ready}, 32'd0);
      check_val("halt_chk", {16'd0, chk_count}, 32'd1);
      do_clr(1'b1);
      check_val("clr_ready", {31'd0, in_ready}, 32'd1);
      check_val("clr_chk", {16'd0, chk_count}, 32'd0);

      // clr on the compare edge of a mismatch wins.
      cyc(1'b1, 16'd2000, 16'd1000, 1'b0, 16'd2999, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1, 1'b1);
      do_clr(1'b1);
      idle(2, 1'b1);
      check_val("clr_pri_err", {16'd0, err_count}, 32'd0);
      check_val("clr_pri_rdy", {31'd0, in_ready}, 32'd1);

      // Saturation of the 4-bit counter.
      for (int i = 0; i < 20; i++) good(16'(i * 37), 16'(i * 11), i[0], 1'b0);
      idle(2, 1'b0);
      check_val("sat4", {28'd0, d4_chk_count}, 32'd15);
      check_val("sat16", {16'd0, chk_count}, 32'd20);

      // Reset mid-pipeline discards in-flight work.
      good(16'd10, 16'd20, 1'b0, 1'b0);
      cyc(1'b1, 16'd1, 16'd1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      check_val("rst_mid", {16'd0, chk_count}, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         ra = pick_word(); rb = pick_word(); rop = 1'($urandom_range(0, 1));
         ref_calc(ra, rb, rop, ro, rov, rcy);
         k = $urandom_range(0, 9);
         if (k == 0) ro = ro ^ (16'd1 << $urandom_range(0, 15));
         else if (k == 1) rov = ~rov;
         else if (k == 2) rcy = ~rcy;
         rv = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 59) == 0) || (m_halt && ($urandom_range(0, 7) == 0));
         rh = (((i / 150) % 2) == 1);
         rr = ($urandom_range(0, 199) != 0);
         cyc(rv, ra, rb, rop, ro, rov, rcy, rc, rh, rr);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
